// File: rtl/nv_nvdla_cmac_pkg.sv
// CMAC config control shared types.
// Precision codes, FSM states and latched layer config.
package nv_nvdla_cmac_pkg;

  localparam int CMAC_SLCG_NUM = 9;

  localparam logic [1:0] PREC_INT8  = 2'd0;
  localparam logic [1:0] PREC_INT16 = 2'd1;
  localparam logic [1:0] PREC_FP16  = 2'd2;
  localparam logic [1:0] PREC_ILL   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cmac_st_e;

  typedef struct packed {
    logic int8;
    logic int16;
    logic fp16;
    logic wg;
    logic err;
  } cmac_cfg_t;

  localparam cmac_cfg_t CFG_RST = '{
    int8:  1'b0,
    int16: 1'b1,
    fp16:  1'b0,
    wg:    1'b0,
    err:   1'b0
  };

endpackage

// File: rtl/nv_nvdla_cmac_slcg_pipe.sv
// Winograd clock-gate enable pipeline.
// Each stage advances only when the load strobe reaches it.
module nv_nvdla_cmac_slcg_pipe
  import nv_nvdla_cmac_pkg::*;
#(
  parameter int SLCG_NUM = CMAC_SLCG_NUM,
  parameter int SLCG_DLY = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [SLCG_NUM-1:0] din_i,
  output logic [SLCG_NUM-1:0] dout_o
);

  logic [SLCG_DLY-1:0] gate;
  logic [SLCG_NUM-1:0] stg [SLCG_DLY+1];

  assign stg[0]  = din_i;
  assign gate[0] = en_i;

  for (genvar k = 0; k < SLCG_DLY; k++) begin : g_stg
    logic [SLCG_NUM-1:0] q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        q <= '0;
      end else if (gate[k]) begin
        q <= stg[k];
      end
    end

    assign stg[k+1] = q;

    // strobe delayed by k+1 gates the next stage
    if (k < SLCG_DLY - 1) begin : g_en
      logic en_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          en_q <= 1'b0;
        end else begin
          en_q <= gate[k];
        end
      end

      assign gate[k+1] = en_q;
    end
  end

  assign dout_o = stg[SLCG_DLY];

endmodule

// File: rtl/nv_nvdla_cmac_cfg_ctrl.sv
// CMAC layer config latch, op FSM, counters
// and clock-gate enable generation.
module nv_nvdla_cmac_cfg_ctrl
  import nv_nvdla_cmac_pkg::*;
#(
  parameter int SLCG_NUM = CMAC_SLCG_NUM,
  parameter int SLCG_DLY = 2,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                reg2dp_op_en,
  input  logic                reg2dp_conv_mode,
  input  logic [1:0]          reg2dp_proc_precision,
  input  logic                dp2reg_done,
  output logic                cfg_reg_en,
  output logic                cfg_is_int8,
  output logic                cfg_is_int16,
  output logic                cfg_is_fp16,
  output logic                cfg_is_wg,
  output logic                cfg_prec_err,
  output logic                op_busy,
  output logic [CNT_W-1:0]    op_cnt,
  output logic [SLCG_NUM-1:0] slcg_wg_en,
  output logic [SLCG_NUM-1:0] slcg_idle_en
);

  localparam logic [7:0] HOLD_V = 8'(HOLD_CYC);

  cmac_st_e         state_q, state_d;
  cmac_cfg_t        cfg_q, cfg_d;
  logic             op_en_d1_q;
  logic             op_done_d1_q;
  logic             cfg_reg_en_q;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [7:0]       idle_q, idle_d;
  logic             load_w;

  assign load_w = (~op_en_d1_q | op_done_d1_q) & reg2dp_op_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load_w) state_d = ST_RUN;
      ST_RUN:  if (op_done_d1_q && !load_w) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_d = cfg_q;
    if (load_w) begin
      cfg_d    = '0;
      cfg_d.wg = reg2dp_conv_mode;
      unique case (1'b1)
        reg2dp_proc_precision == PREC_INT8:  cfg_d.int8  = 1'b1;
        reg2dp_proc_precision == PREC_INT16: cfg_d.int16 = 1'b1;
        reg2dp_proc_precision == PREC_FP16:  cfg_d.fp16  = 1'b1;
        reg2dp_proc_precision == PREC_ILL:   cfg_d.err   = 1'b1;
        default:                             cfg_d.err   = 1'b1;
      endcase
    end
  end

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (state_q == ST_RUN && op_done_d1_q) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
    end
  end

  // idle run length, saturating at the hold threshold
  always_comb begin
    idle_d = idle_q;
    if (state_q == ST_RUN || load_w) begin
      idle_d = '0;
    end else if (idle_q != HOLD_V) begin
      idle_d = idle_q + 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= CFG_RST;
      op_en_d1_q   <= 1'b0;
      op_done_d1_q <= 1'b0;
      cfg_reg_en_q <= 1'b0;
      op_cnt_q     <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      op_en_d1_q   <= reg2dp_op_en;
      op_done_d1_q <= dp2reg_done;
      cfg_reg_en_q <= load_w;
      op_cnt_q     <= op_cnt_d;
      idle_q       <= idle_d;
    end
  end

  nv_nvdla_cmac_slcg_pipe #(
    .SLCG_NUM (SLCG_NUM),
    .SLCG_DLY (SLCG_DLY)
  ) u_wg_pipe (
    .clk_i  (nvdla_core_clk),
    .rst_i  (nvdla_core_rst),
    .en_i   (cfg_reg_en_q),
    .din_i  ({SLCG_NUM{cfg_q.wg}}),
    .dout_o (slcg_wg_en)
  );

  assign cfg_reg_en   = cfg_reg_en_q;
  assign cfg_is_int8  = cfg_q.int8;
  assign cfg_is_int16 = cfg_q.int16;
  assign cfg_is_fp16  = cfg_q.fp16;
  assign cfg_is_wg    = cfg_q.wg;
  assign cfg_prec_err = cfg_q.err;
  assign op_busy      = (state_q == ST_RUN);
  assign op_cnt       = op_cnt_q;
  assign slcg_idle_en = {SLCG_NUM{idle_q == HOLD_V && !load_w}};

endmodule

// File: tb/tb_nv_nvdla_cmac_cfg_ctrl.sv
// Bench for nv_nvdla_cmac_cfg_ctrl: directed table,
// hand sequences and random traffic vs a history model.
module tb_nv_nvdla_cmac_cfg_ctrl;

  localparam int NUM  = 9;
  localparam int DLY  = 2;
  localparam int HOLD = 4;
  localparam int CW   = 8;
  localparam int HMAX = 8192;

  logic           clk = 1'b0;
  logic           rst, en, mode, done;
  logic [1:0]     prec;
  logic           cfg_reg_en, cfg_is_int8, cfg_is_int16;
  logic           cfg_is_fp16, cfg_is_wg, cfg_prec_err, op_busy;
  logic [CW-1:0]  op_cnt;
  logic [NUM-1:0] slcg_wg_en, slcg_idle_en;

  nv_nvdla_cmac_cfg_ctrl #(
    .SLCG_NUM (NUM),
    .SLCG_DLY (DLY),
    .HOLD_CYC (HOLD),
    .CNT_W    (CW)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .reg2dp_op_en          (en),
    .reg2dp_conv_mode      (mode),
    .reg2dp_proc_precision (prec),
    .dp2reg_done           (done),
    .cfg_reg_en            (cfg_reg_en),
    .cfg_is_int8           (cfg_is_int8),
    .cfg_is_int16          (cfg_is_int16),
    .cfg_is_fp16           (cfg_is_fp16),
    .cfg_is_wg             (cfg_is_wg),
    .cfg_prec_err          (cfg_prec_err),
    .op_busy               (op_busy),
    .op_cnt                (op_cnt),
    .slcg_wg_en            (slcg_wg_en),
    .slcg_idle_en          (slcg_idle_en)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [23:0] pack_dut();
    return {cfg_reg_en, cfg_is_int8, cfg_is_int16, cfg_is_fp16,
            cfg_is_wg, cfg_prec_err, op_busy, op_cnt, slcg_wg_en};
  endfunction

  // history model: one entry per clock edge
  bit   h_rst [HMAX];
  bit   h_en  [HMAX];
  bit   h_done[HMAX];
  bit   h_ld  [HMAX];
  bit   h_idle[HMAX];
  bit   h_wg  [HMAX];
  int   e = 0;
  int   last_rst = -1;
  bit   m_init = 0;
  bit   m_busy = 0;
  int   m_cnt = 0;
  bit   m_have = 0;
  logic [1:0] m_prec = 2'd0;
  bit   m_mode = 0;

  task automatic cyc(input bit r, input bit ie, input bit im,
                     input logic [1:0] ip, input bit id,
                     output logic [NUM-1:0] idle_seen);
    bit prev_ok, en_p, done_p, ld_raw, ld, xi, wgv, found;
    bit i8, i16, f16, er, wgd;
    int k;
    logic [23:0] exp_o;
    rst = r; en = ie; mode = im; prec = ip; done = id;
    prev_ok = (e > 0) && !h_rst[e-1];
    en_p    = prev_ok && h_en[e-1];
    done_p  = prev_ok && h_done[e-1];
    ld_raw  = ie && (!en_p || done_p);
    ld      = ld_raw && !r;
    k = 0;
    while (k < HOLD && e - 1 - k >= 0 && h_idle[e-1-k]) k++;
    xi = !ld_raw && (k == HOLD);
    #1;
    idle_seen = slcg_idle_en;
    if (m_init) chk("idle_en", slcg_idle_en, xi ? {NUM{1'b1}} : '0);
    h_rst[e] = r; h_en[e] = ie; h_done[e] = id;
    h_ld[e] = ld; h_wg[e] = im;
    h_idle[e] = !r && !m_busy && !ld;
    if (r) begin
      m_busy = 0; m_cnt = 0; m_have = 0; last_rst = e;
    end else begin
      if (m_busy && done_p) m_cnt = (m_cnt + 1) % (1 << CW);
      if (!m_busy) m_busy = ld;
      else if (done_p && !ld) m_busy = 0;
      if (ld) begin
        m_have = 1; m_prec = ip; m_mode = im;
      end
    end
    if (m_have) begin
      i8 = (m_prec == 0); i16 = (m_prec == 1);
      f16 = (m_prec == 2); er = (m_prec == 3); wgd = m_mode;
    end else begin
      i8 = 0; i16 = 1; f16 = 0; er = 0; wgd = 0;
    end
    // wg gate output follows the newest load at least DLY edges old
    wgv = 0; found = 0;
    for (int j = e - DLY; j > last_rst && j >= 0 && !found; j--) begin
      if (h_ld[j]) begin
        wgv = h_wg[j]; found = 1;
      end
    end
    exp_o = {ld, i8, i16, f16, wgd, er, m_busy, 8'(m_cnt), {NUM{wgv}}};
    e++;
    @(posedge clk);
    @(negedge clk);
    chk("outputs", pack_dut(), exp_o);
    if (r) m_init = 1;
  endtask

  typedef struct {
    bit en; bit mode; logic [1:0] prec; bit done; bit idle;
    bit cfg; bit i8; bit i16; bit f16; bit err; bit wg; bit busy;
    int cnt; bit wgen;
  } vec_t;

  function automatic vec_t mk(bit a_en, bit a_md, logic [1:0] a_pr,
      bit a_dn, bit a_id, bit a_cf, bit a_i8, bit a_i16, bit a_f16,
      bit a_er, bit a_wg, bit a_bs, int a_cn, bit a_ge);
    vec_t v;
    v.en = a_en; v.mode = a_md; v.prec = a_pr; v.done = a_dn;
    v.idle = a_id; v.cfg = a_cf; v.i8 = a_i8; v.i16 = a_i16;
    v.f16 = a_f16; v.err = a_er; v.wg = a_wg; v.busy = a_bs;
    v.cnt = a_cn; v.wgen = a_ge;
    return v;
  endfunction

  vec_t tbl[22];
  logic [NUM-1:0] seen;
  logic [23:0] tpack;
  bit r_en;

  initial begin
    tbl[0]  = mk(1,1,0,0, 0, 1,1,0,0,0,1,1,0,0);
    tbl[1]  = mk(1,1,0,0, 0, 0,1,0,0,0,1,1,0,0);
    tbl[2]  = mk(1,1,0,0, 0, 0,1,0,0,0,1,1,0,1);
    tbl[3]  = mk(1,0,2,0, 0, 0,1,0,0,0,1,1,0,1);
    tbl[4]  = mk(1,0,2,1, 0, 0,1,0,0,0,1,1,0,1);
    tbl[5]  = mk(1,0,2,0, 0, 1,0,0,1,0,0,1,1,1);
    tbl[6]  = mk(1,0,2,0, 0, 0,0,0,1,0,0,1,1,1);
    tbl[7]  = mk(1,0,2,0, 0, 0,0,0,1,0,0,1,1,0);
    tbl[8]  = mk(1,0,3,1, 0, 0,0,0,1,0,0,1,1,0);
    tbl[9]  = mk(1,0,3,0, 0, 1,0,0,0,1,0,1,2,0);
    tbl[10] = mk(0,0,3,1, 0, 0,0,0,0,1,0,1,2,0);
    tbl[11] = mk(0,0,3,0, 0, 0,0,0,0,1,0,0,3,0);
    tbl[12] = mk(0,0,3,0, 0, 0,0,0,0,1,0,0,3,0);
    tbl[13] = mk(0,0,3,0, 0, 0,0,0,0,1,0,0,3,0);
    tbl[14] = mk(0,0,3,0, 0, 0,0,0,0,1,0,0,3,0);
    tbl[15] = mk(0,0,3,0, 0, 0,0,0,0,1,0,0,3,0);
    tbl[16] = mk(0,0,3,0, 1, 0,0,0,0,1,0,0,3,0);
    tbl[17] = mk(1,0,1,0, 0, 1,0,1,0,0,0,1,3,0);
    tbl[18] = mk(1,0,1,1, 0, 0,0,1,0,0,0,1,3,0);
    tbl[19] = mk(0,0,1,0, 0, 0,0,1,0,0,0,0,4,0);
    tbl[20] = mk(0,0,1,1, 0, 0,0,1,0,0,0,0,4,0);
    tbl[21] = mk(0,0,1,0, 0, 0,0,1,0,0,0,0,4,0);

    // reset with op_en already high
    cyc(1, 1, 1, 2'd0, 0, seen);
    cyc(1, 1, 1, 2'd0, 0, seen);
    chk("rst_int16", cfg_is_int16, 1);
    chk("rst_busy", op_busy, 0);
    chk("rst_cnt", op_cnt, 0);
    chk("rst_wg_en", slcg_wg_en, 0);

    for (int i = 0; i < 22; i++) begin
      cyc(0, tbl[i].en, tbl[i].mode, tbl[i].prec, tbl[i].done, seen);
      tpack = {tbl[i].cfg, tbl[i].i8, tbl[i].i16, tbl[i].f16,
               tbl[i].wg, tbl[i].err, tbl[i].busy, 8'(tbl[i].cnt),
               {NUM{tbl[i].wgen}}};
      chk($sformatf("tbl%0d_idle", i), seen,
          tbl[i].idle ? {NUM{1'b1}} : '0);
      chk($sformatf("tbl%0d_out", i), pack_dut(), tpack);
    end

    // 256 back-to-back layers wrap the counter
    cyc(1, 0, 0, 2'd0, 0, seen);
    cyc(0, 1, 0, 2'd0, 0, seen);
    for (int i = 0; i < 256; i++) begin
      cyc(0, 1, 0, 2'd0, 1, seen);
      cyc(0, 1, 0, 2'd0, 0, seen);
    end
    chk("wrap_cnt", op_cnt, 0);
    chk("wrap_busy", op_busy, 1);

    // reset mid-layer with a done in flight
    cyc(0, 1, 0, 2'd0, 1, seen);
    cyc(1, 1, 0, 2'd2, 0, seen);
    chk("midrst_busy", op_busy, 0);
    chk("midrst_cnt", op_cnt, 0);
    cyc(0, 1, 0, 2'd2, 0, seen);
    chk("postrst_load", cfg_reg_en, 1);
    chk("postrst_fp16", cfg_is_fp16, 1);

    r_en = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) r_en = !r_en;
      cyc($urandom_range(99) == 0, r_en, 1'($urandom_range(1)),
          2'($urandom_range(3)), $urandom_range(5) == 0, seen);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cmac_cfg_ctrl.md
NV_NVDLA_CMAC_CFG_CTRL -- requirements
Module: nv_nvdla_cmac_cfg_ctrl

Interface
REQ-001 SHALL have parameter SLCG_NUM, default 9: width of each clock-gate enable vector.
REQ-002 SHALL have parameter SLCG_DLY, default 2, legal range 1..4: number of stages in the wg clock-gate enable pipeline.
REQ-003 SHALL have parameter HOLD_CYC, default 4, legal range 1..255: number of consecutive idle cycles before idle clock gating asserts.
REQ-004 SHALL have parameter CNT_W, default 8: width of the operation counter.
REQ-005 nvdla_core_clk  in  1  sole clock; all logic on rising edge.
REQ-006 nvdla_core_rst  in  1  reset, synchronous and active-high.
REQ-007 reg2dp_op_en  in  1  layer enable, level.
REQ-008 reg2dp_conv_mode  in  1  1 = winograd.
REQ-009 reg2dp_proc_precision  in  2  0 = int8, 1 = int16, 2 = fp16, 3 = illegal.
REQ-010 dp2reg_done  in  1  single-cycle layer-done pulse.
REQ-011 cfg_reg_en  out  1  single-cycle config-load strobe.
REQ-012 cfg_is_int8, cfg_is_int16, cfg_is_fp16, cfg_is_wg  out  1 each  latched decode of the active layer.
REQ-013 cfg_prec_err  out  1  latched layer used illegal precision 3.
REQ-014 op_busy  out  1  layer in progress.
REQ-015 op_cnt  out  CNT_W  count of completed layers.
REQ-016 slcg_wg_en  out  SLCG_NUM  winograd clock-gate enables.
REQ-017 slcg_idle_en  out  SLCG_NUM  idle clock-gate enables.

Function
REQ-018 SHALL register reg2dp_op_en into op_en_d1 and dp2reg_done into op_done_d1.
REQ-019 SHALL form load_w = (~op_en_d1 | op_done_d1) & reg2dp_op_en; cfg_reg_en SHALL be load_w registered (latency 1).
REQ-020 SHALL implement a 2-state FSM: IDLE -> RUN when load_w = 1; RUN -> IDLE when op_done_d1 = 1 and load_w = 0; RUN -> RUN when op_done_d1 = 1 and load_w = 1 (back-to-back layer); IDLE with op_done_d1 = 1 SHALL stay IDLE.
REQ-021 op_busy SHALL be 1 exactly when the FSM is in RUN.
REQ-022 Decode outputs and cfg_prec_err SHALL update only in the cycle cfg_reg_en is driven to 1, and hold otherwise; register changes mid-layer SHALL be ignored.
REQ-023 Precision 3 SHALL load cfg_prec_err = 1 and all three precision flags = 0; any legal precision SHALL load cfg_prec_err = 0 with exactly one precision flag set.
REQ-024 op_cnt SHALL increment by one on every op_done_d1 = 1 while in RUN and wrap from 2^CNT_W - 1 to 0; done in IDLE SHALL not count.
REQ-025 The wg pipeline SHALL have SLCG_DLY stages: stage 1 loads {SLCG_NUM{cfg_is_wg}} when cfg_reg_en = 1; stage k loads stage k-1 when cfg_reg_en delayed by k-1 cycles = 1; slcg_wg_en SHALL be the last stage, so the new value appears SLCG_DLY cycles after cfg_reg_en.
REQ-026 An idle counter (8-bit, saturating at HOLD_CYC) SHALL increment each IDLE cycle and clear to 0 in RUN or when load_w = 1.
REQ-027 slcg_idle_en SHALL be all ones while the idle counter equals HOLD_CYC and load_w = 0; it SHALL be all zeros otherwise, and SHALL drop in the same cycle load_w rises.

Reset
REQ-028 While nvdla_core_rst = 1 at a clock edge, SHALL set: FSM IDLE, op_en_d1 = 0, op_done_d1 = 0, cfg_reg_en = 0, cfg_is_int8 = 0, cfg_is_int16 = 1, cfg_is_fp16 = 0, cfg_is_wg = 0, cfg_prec_err = 0, op_cnt = 0, all wg stages = 0, idle counter = 0.
REQ-029 Reset asserted mid-layer SHALL abort it with no done count; the first cycle after reset with reg2dp_op_en = 1 SHALL launch a load.

Structure
REQ-030 SHALL place the precision encodings (0/1/2/3), the FSM state encoding and the SLCG_NUM default in package nv_nvdla_cmac_pkg.
REQ-031 SHALL implement the wg pipeline as sub-module nv_nvdla_cmac_slcg_pipe, parametrised by SLCG_NUM and SLCG_DLY.

Verification
REQ-032 Reset release with op_en = 1, precision 0, conv_mode = 1 -> cfg_reg_en high at cycle 1 with cfg_is_int8 = 1; slcg_wg_en = 0x1FF at cycle 3 (defaults).
REQ-033 Done pulse while op_en stays 1 -> second cfg_reg_en 2 cycles after done; op_busy never drops; op_cnt = 1.
REQ-034 Precision changed to 2 mid-layer -> cfg_is_fp16 stays 0 until the next cfg_reg_en.
REQ-035 Precision 3 load -> cfg_prec_err = 1 and all precision flags 0.
REQ-036 op_en = 0 after done -> slcg_idle_en = 0x1FF after HOLD_CYC = 4 idle cycles; raising op_en clears it in the same cycle.
REQ-037 256 layers at CNT_W = 8 -> op_cnt wraps to 0; reset mid-RUN -> op_busy = 0 and op_cnt = 0.
